midi_cmd_master: RTL and testbench

MIDI_CMD_MASTER -- requirements
Module: midi_cmd_master

---
 rtl/midi_cmd_master_if.sv | 18 +
 rtl/midi_cmd_master.sv | 202 ++++++++++++++++++++
 tb/tb_midi_cmd_master.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/midi_cmd_master_if.sv
// Avalon-MM write-only channel between the MIDI command master and the synthesizer slave.
interface midi_cmd_master_if;
    logic        avm_m0_write;
    logic [31:0] avm_m0_writedata;
    logic        avm_m0_waitrequest;

    modport master (
        output avm_m0_write,
        output avm_m0_writedata,
        input  avm_m0_waitrequest
    );

    modport slave (
        input  avm_m0_write,
        input  avm_m0_writedata,
        output avm_m0_waitrequest
    );
endinterface

// File: rtl/midi_cmd_master.sv
// MIDI byte-stream parser feeding a command FIFO that is drained over an Avalon-MM master.
// Note on/off and all-notes-off commands are forwarded; everything else is filtered out.
module midi_cmd_master #(
    parameter int unsigned CHANNEL = 0,
    parameter int unsigned OMNI    = 0,
    parameter int unsigned DEPTH   = 8,
    localparam int unsigned AW     = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [7:0]           i_byte,
    input  logic                 i_byte_valid,
    midi_cmd_master_if.master    avm_m0,
    output logic [AW:0]          o_fifo_count,
    output logic [7:0]           o_drop_count
);

    typedef enum logic [1:0] {StIdle, StData1, StData2, StSkip} parse_st_e;
    typedef enum logic [1:0] {StMstIdle, StMstLoad, StMstWrite} mst_st_e;

    parse_st_e   state_q, state_d;
    logic [7:0]  rs_q, rs_d;
    logic        rs_valid_q, rs_valid_d;
    logic [6:0]  d1_q, d1_d;
    logic        cmd_valid;
    logic [15:0] cmd;

    logic [15:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic [7:0]    drop_q;
    logic          full, push, pop, drop;

    mst_st_e     mst_q, mst_d;
    logic        write_q, write_d;
    logic [31:0] wdata_q, wdata_d;

    function automatic logic is_tracked(input logic [7:0] st);
        logic kind_ok;
        logic chan_ok;
        kind_ok = (st[7:4] == 4'h8) || (st[7:4] == 4'h9) || (st[7:4] == 4'hB);
        chan_ok = (OMNI != 0) || (st[3:0] == 4'(CHANNEL));
        return kind_ok && chan_ok;
    endfunction

    logic is_sys, is_status;
    assign is_sys    = (i_byte[7:3] == 5'b11110);
    assign is_status = i_byte[7] && (i_byte[7:4] != 4'hF);

    always_comb begin
        state_d    = state_q;
        rs_d       = rs_q;
        rs_valid_d = rs_valid_q;
        d1_d       = d1_q;
        cmd_valid  = 1'b0;
        cmd        = 16'h0000;
        // Realtime bytes (F8-FF) fall through every branch and leave state untouched.
        if (i_byte_valid) begin
            if (is_sys) begin
                rs_valid_d = 1'b0;
                state_d    = StIdle;
            end else if (is_status) begin
                rs_d       = i_byte;
                rs_valid_d = 1'b1;
                state_d    = StData1;
            end else if (!i_byte[7]) begin
                case (state_q)
                    StIdle, StData1: begin
                        if (state_q == StData1 || rs_valid_q) begin
                            if (is_tracked(rs_q)) begin
                                d1_d    = i_byte[6:0];
                                state_d = StData2;
                            end else if (rs_q[7:5] == 3'b110) begin
                                state_d = StIdle;
                            end else begin
                                state_d = StSkip;
                            end
                        end
                    end
                    StData2: begin
                        state_d = StIdle;
                        case (rs_q[7:4])
                            4'h9: begin
                                cmd_valid = 1'b1;
                                cmd = (i_byte != 8'h00) ? {1'b1, d1_q, i_byte}
                                                        : {1'b0, d1_q, 8'h00};
                            end
                            4'h8: begin
                                cmd_valid = 1'b1;
                                cmd       = {1'b0, d1_q, 8'h00};
                            end
                            4'hB: begin
                                if (d1_q == 7'd123) begin
                                    cmd_valid = 1'b1;
                                    cmd       = 16'h7F00;
                                end
                            end
                            default: ;
                        endcase
                    end
                    default: state_d = StIdle;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= StIdle;
            rs_q       <= 8'h00;
            rs_valid_q <= 1'b0;
            d1_q       <= 7'h00;
        end else begin
            state_q    <= state_d;
            rs_q       <= rs_d;
            rs_valid_q <= rs_valid_d;
            d1_q       <= d1_d;
        end
    end

    // The head entry stays queued until the slave accepts it, so it counts towards occupancy.
    assign full = (count_q == (AW + 1)'(DEPTH));
    assign pop  = (mst_q == StMstWrite) && !avm_m0.avm_m0_waitrequest;
    assign push = cmd_valid && (!full || pop);
    assign drop = cmd_valid && full && !pop;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= cmd;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            drop_q   <= 8'h00;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !push) begin
                count_q <= count_q - 1'b1;
            end
            if (drop && drop_q != 8'hFF) begin
                drop_q <= drop_q + 1'b1;
            end
        end
    end

    always_comb begin
        mst_d   = mst_q;
        write_d = write_q;
        wdata_d = wdata_q;
        case (mst_q)
            StMstIdle: begin
                if (count_q != '0) begin
                    wdata_d = {16'h0000, mem_q[rd_ptr_q]};
                    mst_d   = StMstLoad;
                end
            end
            StMstLoad: begin
                write_d = 1'b1;
                mst_d   = StMstWrite;
            end
            StMstWrite: begin
                if (!avm_m0.avm_m0_waitrequest) begin
                    write_d = 1'b0;
                    mst_d   = StMstIdle;
                end
            end
            default: begin
                write_d = 1'b0;
                mst_d   = StMstIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            mst_q   <= StMstIdle;
            write_q <= 1'b0;
            wdata_q <= 32'h0;
        end else begin
            mst_q   <= mst_d;
            write_q <= write_d;
            wdata_q <= wdata_d;
        end
    end

    assign avm_m0.avm_m0_write     = write_q;
    assign avm_m0.avm_m0_writedata = wdata_q;
    assign o_fifo_count            = count_q;
    assign o_drop_count            = drop_q;

endmodule

// File: tb/tb_midi_cmd_master.sv
// Directed bench for midi_cmd_master: table of byte streams with expected writes,
// plus hand-written latency, backpressure/overflow and mid-transfer reset sequences.
module tb_midi_cmd_master;

    logic       clk;
    logic       reset;
    logic [7:0] i_byte;
    logic       i_byte_valid;
    logic [3:0] o_fifo_count;
    logic [7:0] o_drop_count;

    midi_cmd_master_if bus ();

    midi_cmd_master #(
        .CHANNEL(0),
        .OMNI(0),
        .DEPTH(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .i_byte(i_byte),
        .i_byte_valid(i_byte_valid),
        .avm_m0(bus),
        .o_fifo_count(o_fifo_count),
        .o_drop_count(o_drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  b [6];
        int          n;
        int          nexp;
        logic [31:0] e [2];
    } vec_t;

    vec_t        vecs [16];
    int          nv;
    int          pass_cnt;
    int          total_cnt;
    logic [31:0] wr_q [$];
    logic [31:0] exp_cmd [10];

    // Completed transfers: write high while the slave is not stalling.
    always @(negedge clk) begin
        if (reset && bus.avm_m0_write && !bus.avm_m0_waitrequest) begin
            wr_q.push_back(bus.avm_m0_writedata);
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic add_vec(input int n, input logic [7:0] x0, input logic [7:0] x1,
                           input logic [7:0] x2, input logic [7:0] x3, input logic [7:0] x4,
                           input logic [7:0] x5, input int ne, input logic [31:0] e0,
                           input logic [31:0] e1);
        vecs[nv].b[0] = x0;
        vecs[nv].b[1] = x1;
        vecs[nv].b[2] = x2;
        vecs[nv].b[3] = x3;
        vecs[nv].b[4] = x4;
        vecs[nv].b[5] = x5;
        vecs[nv].n    = n;
        vecs[nv].nexp = ne;
        vecs[nv].e[0] = e0;
        vecs[nv].e[1] = e1;
        nv++;
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        i_byte       = b;
        i_byte_valid = 1'b1;
        @(posedge clk);
        #1;
        i_byte_valid = 1'b0;
    endtask

    task automatic do_reset(input logic chk);
        @(negedge clk);
        reset        = 1'b0;
        i_byte_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        if (chk) begin
            check("rst_write", {31'b0, bus.avm_m0_write}, 32'd0);
            check("rst_wdata", bus.avm_m0_writedata, 32'd0);
            check("rst_fifo_count", {28'b0, o_fifo_count}, 32'd0);
            check("rst_drop_count", {24'b0, o_drop_count}, 32'd0);
        end
        reset = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] first;
        int          t;
        pass_cnt                = 0;
        total_cnt               = 0;
        nv                      = 0;
        reset                   = 1'b0;
        i_byte                  = 8'h00;
        i_byte_valid            = 1'b0;
        bus.avm_m0_waitrequest  = 1'b0;

        add_vec(3, 8'h90, 8'h45, 8'h40, 8'h00, 8'h00, 8'h00, 1, 32'h0000C540, 32'h0);
        add_vec(5, 8'h90, 8'h24, 8'h64, 8'h24, 8'h00, 8'h00, 2, 32'h0000A464, 32'h00002400);
        add_vec(4, 8'h90, 8'h45, 8'hF8, 8'h40, 8'h00, 8'h00, 1, 32'h0000C540, 32'h0);
        add_vec(3, 8'hB0, 8'h7B, 8'h00, 8'h00, 8'h00, 8'h00, 1, 32'h00007F00, 32'h0);
        add_vec(3, 8'hB0, 8'h07, 8'h64, 8'h00, 8'h00, 8'h00, 0, 32'h0, 32'h0);
        add_vec(5, 8'hC0, 8'h05, 8'h90, 8'h30, 8'h10, 8'h00, 1, 32'h0000B010, 32'h0);
        add_vec(3, 8'h91, 8'h45, 8'h40, 8'h00, 8'h00, 8'h00, 0, 32'h0, 32'h0);
        add_vec(3, 8'h80, 8'h3C, 8'h40, 8'h00, 8'h00, 8'h00, 1, 32'h00003C00, 32'h0);
        add_vec(3, 8'h90, 8'h3C, 8'h00, 8'h00, 8'h00, 8'h00, 1, 32'h00003C00, 32'h0);
        add_vec(5, 8'h90, 8'h10, 8'hF0, 8'h11, 8'h12, 8'h00, 0, 32'h0, 32'h0);
        add_vec(5, 8'h90, 8'h10, 8'h80, 8'h20, 8'h30, 8'h00, 1, 32'h00002000, 32'h0);
        add_vec(6, 8'hE0, 8'h01, 8'h02, 8'h90, 8'h50, 8'h7F, 1, 32'h0000D07F, 32'h0);
        add_vec(6, 8'hA0, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 0, 32'h0, 32'h0);
        add_vec(4, 8'h9F, 8'h20, 8'h30, 8'h40, 8'h00, 8'h00, 0, 32'h0, 32'h0);

        for (int v = 0; v < nv; v++) begin
            do_reset(v == 0);
            wr_q.delete();
            for (int i = 0; i < vecs[v].n; i++) begin
                send(vecs[v].b[i]);
            end
            repeat (16) @(posedge clk);
            #1;
            check($sformatf("vec%0d_nwrites", v), wr_q.size(), vecs[v].nexp);
            for (int k = 0; k < vecs[v].nexp; k++) begin
                check($sformatf("vec%0d_wdata%0d", v, k),
                      (k < wr_q.size()) ? wr_q[k] : 32'hFFFF_FFFF, vecs[v].e[k]);
            end
        end

        // Latency and write pulse width.
        do_reset(1'b0);
        send(8'h90);
        send(8'h45);
        send(8'h40);
        @(posedge clk);
        #1;
        check("lat_edge1_write", {31'b0, bus.avm_m0_write}, 32'd0);
        @(posedge clk);
        #1;
        check("lat_edge2_write", {31'b0, bus.avm_m0_write}, 32'd1);
        check("lat_edge2_wdata", bus.avm_m0_writedata, 32'h0000C540);
        @(posedge clk);
        #1;
        check("lat_edge3_write", {31'b0, bus.avm_m0_write}, 32'd0);

        // Backpressure with overflow: 10 note-ons into an 8-deep queue.
        do_reset(1'b0);
        bus.avm_m0_waitrequest = 1'b1;
        for (int i = 0; i < 10; i++) begin
            exp_cmd[i] = {16'h0000, 1'b1, 7'(8'h30 + i), 8'(8'h40 + i)};
        end
        send(8'h90);
        for (int i = 0; i < 10; i++) begin
            send(8'(8'h30 + i));
            send(8'(8'h40 + i));
        end
        @(posedge clk);
        #1;
        check("bp_drop_count", {24'b0, o_drop_count}, 32'd2);
        check("bp_fifo_count", {28'b0, o_fifo_count}, 32'd8);
        first = bus.avm_m0_writedata;
        check("bp_head_wdata", first, exp_cmd[0]);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("bp_hold_write%0d", c), {31'b0, bus.avm_m0_write}, 32'd1);
            check($sformatf("bp_hold_wdata%0d", c), bus.avm_m0_writedata, exp_cmd[0]);
        end
        wr_q.delete();
        @(negedge clk);
        bus.avm_m0_waitrequest = 1'b0;
        t = 0;
        while (wr_q.size() < 8 && t < 200) begin
            @(posedge clk);
            t++;
        end
        repeat (10) @(posedge clk);
        #1;
        check("bp_nwrites", wr_q.size(), 32'd8);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("bp_order%0d", k),
                  (k < wr_q.size()) ? wr_q[k] : 32'hFFFF_FFFF, exp_cmd[k]);
        end
        check("bp_drop_final", {24'b0, o_drop_count}, 32'd2);

        // Reset pulsed while a write is held by waitrequest.
        do_reset(1'b0);
        bus.avm_m0_waitrequest = 1'b1;
        send(8'h90);
        send(8'h45);
        send(8'h40);
        t = 0;
        while (!bus.avm_m0_write && t < 50) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("mr_write_pending", {31'b0, bus.avm_m0_write}, 32'd1);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("mr_write_dropped", {31'b0, bus.avm_m0_write}, 32'd0);
        check("mr_fifo_count", {28'b0, o_fifo_count}, 32'd0);
        check("mr_wdata", bus.avm_m0_writedata, 32'd0);
        reset = 1'b1;
        wr_q.delete();
        @(negedge clk);
        bus.avm_m0_waitrequest = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("mr_no_write_after", wr_q.size(), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
